// File: rtl/decstage.sv
// Decode stage: 32x32 register file with two combinational read ports,
// one synchronous write port, and the immediate-extension unit.
module decstage (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Instr,
  input  logic        RF_WrEn,
  input  logic [31:0] ALU_out,
  input  logic [31:0] MEM_out,
  input  logic        RF_WrData_sel,
  input  logic        RF_B_sel,
  input  logic [1:0]  ImmExt_sel,
  output logic [31:0] Immed,
  output logic [31:0] RF_A,
  output logic [31:0] RF_B
);

  logic [4:0]  rs;
  logic [4:0]  rd;
  logic [4:0]  rt;
  logic [4:0]  rb_addr;
  logic [15:0] imm;
  logic [31:0] wr_data;
  logic [31:0] regs [0:31];
  logic        unused_opcode;

  assign rs  = Instr[25:21];
  assign rd  = Instr[20:16];
  assign rt  = Instr[15:11];
  assign imm = Instr[15:0];
  assign unused_opcode = &{1'b0, Instr[31:26]};

  always_comb begin
    rb_addr = rt;
    wr_data = ALU_out;
    if (RF_B_sel) begin
      rb_addr = rd;
    end else begin
      rb_addr = rt;
    end
    if (RF_WrData_sel) begin
      wr_data = MEM_out;
    end else begin
      wr_data = ALU_out;
    end
  end

  // Reset wins over a same-edge write; R0 is never written so it stays zero.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'h0000_0000;
      end
    end else if (RF_WrEn && (rd != 5'd0)) begin
      regs[rd] <= wr_data;
    end
  end

  // Reads see the pre-edge contents: there is deliberately no write bypass.
  assign RF_A = (rs == 5'd0)      ? 32'h0000_0000 : regs[rs];
  assign RF_B = (rb_addr == 5'd0) ? 32'h0000_0000 : regs[rb_addr];

  always_comb begin
    Immed = 32'h0000_0000;
    case (ImmExt_sel)
      2'b00:   Immed = {{16{imm[15]}}, imm};
      2'b01:   Immed = {16'h0000, imm};
      2'b10:   Immed = {imm, 16'h0000};
      2'b11:   Immed = {{14{imm[15]}}, imm, 2'b00};
      default: Immed = 32'h0000_0000;
    endcase
  end

endmodule

// File: tb/tb_decstage.sv
// Self-checking bench for decstage: directed scenarios followed by random
// traffic compared against an array-based register-file model.
module tb_decstage;

  logic        Clk;
  logic        Reset;
  logic [31:0] Instr;
  logic        RF_WrEn;
  logic [31:0] ALU_out;
  logic [31:0] MEM_out;
  logic        RF_WrData_sel;
  logic        RF_B_sel;
  logic [1:0]  ImmExt_sel;
  logic [31:0] Immed;
  logic [31:0] RF_A;
  logic [31:0] RF_B;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] model [0:31];

  decstage dut (
    .Clk(Clk), .Reset(Reset), .Instr(Instr), .RF_WrEn(RF_WrEn),
    .ALU_out(ALU_out), .MEM_out(MEM_out), .RF_WrData_sel(RF_WrData_sel),
    .RF_B_sel(RF_B_sel), .ImmExt_sel(ImmExt_sel),
    .Immed(Immed), .RF_A(RF_A), .RF_B(RF_B)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  function automatic logic [31:0] mk_instr(input int rs, input int rd, input int rt);
    logic [31:0] v;
    v = 32'h0000_0000;
    v = v + 32'(rs) * 32'h0020_0000 + 32'(rd) * 32'h0001_0000 + 32'(rt) * 32'h0000_0800;
    return v;
  endfunction

  function automatic logic [31:0] model_read(input int addr);
    if (addr == 0) return 32'h0000_0000;
    return model[addr];
  endfunction

  function automatic logic [31:0] model_immed(input logic [15:0] imm, input logic [1:0] sel);
    int signed s;
    s = int'($signed(imm));
    case (sel)
      2'd0:    return 32'(s);
      2'd1:    return 32'(imm);
      2'd2:    return 32'(imm) * 32'h0001_0000;
      2'd3:    return 32'(s * 4);
      default: return 32'h0000_0000;
    endcase
  endfunction

  task automatic set_in(input logic rst, input logic [31:0] ins, input logic wren,
                        input logic [31:0] alu, input logic [31:0] mem,
                        input logic wsel, input logic bsel, input logic [1:0] isel);
    Reset = rst; Instr = ins; RF_WrEn = wren; ALU_out = alu; MEM_out = mem;
    RF_WrData_sel = wsel; RF_B_sel = bsel; ImmExt_sel = isel;
    #1;
  endtask

  // Advance one clock edge, updating the model from the inputs seen at that edge.
  task automatic tick();
    int rd;
    @(posedge Clk);
    rd = int'(Instr[20:16]);
    if (Reset) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0000_0000;
    end else if (RF_WrEn && rd != 0) begin
      model[rd] = RF_WrData_sel ? MEM_out : ALU_out;
    end
    @(negedge Clk);
  endtask

  task automatic check_model(input string tag);
    int ra;
    int rb;
    ra = int'(Instr[25:21]);
    rb = RF_B_sel ? int'(Instr[20:16]) : int'(Instr[15:11]);
    check_eq({tag, "_rfa"}, RF_A, model_read(ra));
    check_eq({tag, "_rfb"}, RF_B, model_read(rb));
    check_eq({tag, "_imm"}, Immed, model_immed(Instr[15:0], ImmExt_sel));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0000_0000;
    @(negedge Clk);
    set_in(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0);
    tick();

    // reset state
    set_in(1'b0, mk_instr(4, 0, 31), 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0);
    check_eq("rst_rfa", RF_A, 32'h0000_0000);
    check_eq("rst_rfb", RF_B, 32'h0000_0000);

    // write R5 via ALU, no bypass in the write cycle
    set_in(1'b0, mk_instr(5, 5, 0), 1'b1, 32'h0000_000C, 32'h5555_5555, 1'b0, 1'b0, 2'd0);
    check_eq("nobypass_rfa", RF_A, 32'h0000_0000);
    tick();
    set_in(1'b0, mk_instr(5, 0, 0), 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0);
    check_eq("wr_r5_rfa", RF_A, 32'h0000_000C);

    // write to R0 ignored
    set_in(1'b0, mk_instr(0, 0, 0), 1'b1, 32'h0, 32'hDEAD_BEEF, 1'b1, 1'b0, 2'd0);
    tick();
    set_in(1'b0, mk_instr(0, 0, 0), 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0);
    check_eq("r0_rfa", RF_A, 32'h0000_0000);

    // reset beats simultaneous write; R5 written earlier is also discarded
    set_in(1'b0, mk_instr(0, 7, 0), 1'b1, 32'h0000_0022, 32'h0, 1'b0, 1'b0, 2'd0);
    tick();
    set_in(1'b0, mk_instr(7, 0, 0), 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0);
    check_eq("pre_rst_r7", RF_A, 32'h0000_0022);
    set_in(1'b1, mk_instr(0, 7, 0), 1'b1, 32'h0000_0011, 32'h0, 1'b0, 1'b0, 2'd0);
    tick();
    set_in(1'b0, mk_instr(7, 0, 5), 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0);
    check_eq("rst_prio_r7", RF_A, 32'h0000_0000);
    check_eq("rst_clr_r5", RF_B, 32'h0000_0000);

    // immediate extension modes
    set_in(1'b0, 32'h0000_FFF5, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0);
    check_eq("imm_sext", Immed, 32'hFFFF_FFF5);
    set_in(1'b0, 32'h0000_FFF5, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd1);
    check_eq("imm_zext", Immed, 32'h0000_FFF5);
    set_in(1'b0, 32'h0000_FFF5, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd2);
    check_eq("imm_hi", Immed, 32'hFFF5_0000);
    set_in(1'b0, 32'h0000_FFF5, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd3);
    check_eq("imm_sl2", Immed, 32'hFFFF_FFD4);
    set_in(1'b1, 32'h0000_7FF5, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd3);
    check_eq("imm_sl2_pos_in_rst", Immed, 32'h0001_FFD4);

    // RF_B address select
    set_in(1'b0, mk_instr(0, 3, 0), 1'b1, 32'h0000_000B, 32'h0, 1'b0, 1'b0, 2'd0);
    tick();
    set_in(1'b0, mk_instr(0, 9, 3), 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0);
    check_eq("bsel_rt", RF_B, 32'h0000_000B);
    set_in(1'b0, mk_instr(0, 9, 3), 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 2'd0);
    check_eq("bsel_rd", RF_B, 32'h0000_0000);
    set_in(1'b0, mk_instr(3, 3, 3), 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 2'd0);
    check_eq("same_addr_a", RF_A, 32'h0000_000B);
    check_eq("same_addr_b", RF_B, 32'h0000_000B);

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      set_in(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0, $urandom,
             ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0, $urandom, $urandom,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)));
      check_model("rand");
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
